hilbert_delay_cfg_ctrl: RTL and testbench

//   Run-time configuration sequencer for the tx_dsp_core Hilbert fractional-sample delay mux.

---
 rtl/hilbert_delay_cfg_ctrl_pkg.sv | 19 +
 rtl/hilbert_delay_cfg_ctrl_if.sv | 23 ++
 rtl/hilbert_delay_cfg_ctrl_sel_calc.sv | 17 +
 rtl/hilbert_delay_cfg_ctrl.sv | 111 +++++++++++
 tb/tb_hilbert_delay_cfg_ctrl.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/hilbert_delay_cfg_ctrl_pkg.sv
// Shared constants and state encoding for the Hilbert fractional-delay mux controller.
package hilbert_tx_pkg;

   localparam int LANES = 8;
   localparam int SEL_W = 4;
   localparam int DLY_W = 3;
   localparam int MUX_W = LANES * SEL_W;

   // Identity lane mapping: lane i selects sample i (delay 0).
   localparam logic [MUX_W-1:0] RST_SEL = 32'h76543210;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ARMED  = 2'd1,
      ST_SWITCH = 2'd2,
      ST_FLUSH  = 2'd3
   } state_t;

endpackage

// File: rtl/hilbert_delay_cfg_ctrl_if.sv
// Configuration request channel between the register bank and the delay controller.
interface hilbert_delay_cfg_ctrl_if;
   import hilbert_tx_pkg::*;

   // Valid/ready: a request transfers on a rising edge where cfg_valid && cfg_ready;
   // the requester holds cfg_valid/cfg_delay stable until then. cfg_done pulses one cycle on completion.
   logic [DLY_W-1:0] cfg_delay;
   logic             cfg_valid;
   logic             cfg_ready;
   logic             cfg_abort;
   logic             cfg_done;

   modport master (
      output cfg_delay, cfg_valid, cfg_abort,
      input  cfg_ready, cfg_done
   );

   modport slave (
      input  cfg_delay, cfg_valid, cfg_abort,
      output cfg_ready, cfg_done
   );

endinterface

// File: rtl/hilbert_delay_cfg_ctrl_sel_calc.sv
// Maps a sample delay to the per-lane select word: lane i picks sample i + delay.
module hilbert_mux_sel_calc
   import hilbert_tx_pkg::*;
(
   input  logic [DLY_W-1:0] delay,
   output logic [MUX_W-1:0] sel
);

   // Max is (LANES-1)+(LANES-1) = 14, which fits SEL_W without wrapping.
   always_comb begin
      sel = '0;
      for (int i = 0; i < LANES; i++) begin
         sel[i*SEL_W +: SEL_W] = SEL_W'(i) + SEL_W'(delay);
      end
   end

endmodule

// File: rtl/hilbert_delay_cfg_ctrl.sv
// Sequences a run-time delay change: arm on request, switch at a frame boundary, mute through the flush.
module hilbert_delay_cfg_ctrl
   import hilbert_tx_pkg::*;
#(
   parameter int FLUSH_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   hilbert_delay_cfg_ctrl_if.slave  cfg,
   input  logic                     frame_sync,
   output logic [DLY_W-1:0]         delay_value,
   output logic [MUX_W-1:0]         mux_select,
   output logic                     data_mute,
   output logic                     busy,
   output state_t                   dbg_state
);

   localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

   state_t            state, state_d;
   logic [DLY_W-1:0]  pending, pending_d;
   logic [CNT_W-1:0]  cnt, cnt_d;
   logic [DLY_W-1:0]  delay_d;
   logic [MUX_W-1:0]  sel_d;
   logic [MUX_W-1:0]  pending_sel;
   logic              mute_d;
   logic              done_q, done_d;
   logic              accept;

   hilbert_mux_sel_calc u_sel_calc (
      .delay (pending),
      .sel   (pending_sel)
   );

   assign cfg.cfg_ready = (state == ST_IDLE) && !rst;
   assign cfg.cfg_done  = done_q;
   assign accept        = cfg.cfg_valid && cfg.cfg_ready;
   assign busy          = (state != ST_IDLE);
   assign dbg_state     = state;

   always_comb begin
      state_d   = state;
      pending_d = pending;
      cnt_d     = cnt;
      delay_d   = delay_value;
      sel_d     = mux_select;
      mute_d    = data_mute;
      done_d    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               // Requesting the delay already in force completes immediately without a mute.
               if (cfg.cfg_delay == delay_value) begin
                  done_d = 1'b1;
               end else begin
                  pending_d = cfg.cfg_delay;
                  state_d   = ST_ARMED;
               end
            end
         end
         ST_ARMED: begin
            if (cfg.cfg_abort) begin
               pending_d = '0;
               state_d   = ST_IDLE;
            end else if (frame_sync) begin
               mute_d  = 1'b1;
               state_d = ST_SWITCH;
            end
         end
         ST_SWITCH: begin
            delay_d = pending;
            sel_d   = pending_sel;
            cnt_d   = CNT_LOAD;
            state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (cnt == '0) begin
               mute_d    = 1'b0;
               done_d    = 1'b1;
               pending_d = '0;
               state_d   = ST_IDLE;
            end else begin
               cnt_d = cnt - 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         pending     <= '0;
         cnt         <= '0;
         delay_value <= '0;
         mux_select  <= RST_SEL;
         data_mute   <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state       <= state_d;
         pending     <= pending_d;
         cnt         <= cnt_d;
         delay_value <= delay_d;
         mux_select  <= sel_d;
         data_mute   <= mute_d;
         done_q      <= done_d;
      end
   end

endmodule

// File: tb/tb_hilbert_delay_cfg_ctrl.sv
// Randomized bench for hilbert_delay_cfg_ctrl against a timeline-level reference model.
module tb_hilbert_delay_cfg_ctrl;
   import hilbert_tx_pkg::*;

   localparam int F = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              frame_sync;
   logic [DLY_W-1:0]  delay_value;
   logic [MUX_W-1:0]  mux_select;
   logic              data_mute;
   logic              busy;
   state_t            dbg_state;

   hilbert_delay_cfg_ctrl_if cfg_bus ();

   hilbert_delay_cfg_ctrl #(.FLUSH_CYCLES(F)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg         (cfg_bus.slave),
      .frame_sync  (frame_sync),
      .delay_value (delay_value),
      .mux_select  (mux_select),
      .data_mute   (data_mute),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int applied = 0;
   logic [31:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Lane i selects sample i+d; each field is 4 bits.
   function automatic logic [31:0] model_sel(input int d);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < LANES; i++) r = r | (32'((i + d) % 16) << (4 * i));
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      cfg_bus.cfg_valid = 1'b0;
      cfg_bus.cfg_abort = 1'b0;
      frame_sync        = 1'b0;
   endtask

   // scoreboard: each cfg_done must show the delay the model expects to complete
   always @(negedge clk) begin
      if (!rst && cfg_bus.cfg_done) begin
         if (exp_q.size() == 0) check("done_unexpected", 32'(cfg_bus.cfg_done), 32'd0);
         else check("done_delay", 32'(delay_value), exp_q.pop_front());
      end
   end

   // driver: one request; gap = idle cycles between accept and frame_sync;
   // rst_at = mute-cycle index (1 = switch cycle) at which to assert reset, 0 for none.
   task automatic request(input int d, input bit fs_accept, input int gap,
                          input bit do_abort, input int rst_at);
      check("ready_pre", 32'(cfg_bus.cfg_ready), 32'd1);
      cfg_bus.cfg_delay = DLY_W'(d);
      cfg_bus.cfg_valid = 1'b1;
      cfg_bus.cfg_abort = 1'($urandom_range(0, 1));
      frame_sync        = fs_accept;
      if (d == applied) begin
         exp_q.push_back(32'(d));
         step();
         clear_inputs();
         check("noop_done", 32'(cfg_bus.cfg_done), 32'd1);
         check("noop_busy", 32'(busy), 32'd0);
         check("noop_mute", 32'(data_mute), 32'd0);
         check("noop_mux", mux_select, model_sel(applied));
         step();
         check("noop_done_clr", 32'(cfg_bus.cfg_done), 32'd0);
         check("noop_mute2", 32'(data_mute), 32'd0);
         return;
      end
      step();
      clear_inputs();
      check("armed_busy", 32'(busy), 32'd1);
      check("armed_ready", 32'(cfg_bus.cfg_ready), 32'd0);
      check("armed_mute", 32'(data_mute), 32'd0);
      check("armed_delay", 32'(delay_value), 32'(applied));
      for (int g = 0; g < gap; g++) begin
         cfg_bus.cfg_valid = 1'($urandom_range(0, 1));
         cfg_bus.cfg_delay = DLY_W'($urandom_range(0, 7));
         step();
         check("wait_mute", 32'(data_mute), 32'd0);
         check("wait_busy", 32'(busy), 32'd1);
         check("wait_mux", mux_select, model_sel(applied));
      end
      clear_inputs();
      if (do_abort) begin
         cfg_bus.cfg_abort = 1'b1;
         frame_sync        = 1'($urandom_range(0, 1));
         step();
         clear_inputs();
         check("abort_busy", 32'(busy), 32'd0);
         check("abort_ready", 32'(cfg_bus.cfg_ready), 32'd1);
         check("abort_mute", 32'(data_mute), 32'd0);
         check("abort_done", 32'(cfg_bus.cfg_done), 32'd0);
         check("abort_delay", 32'(delay_value), 32'(applied));
         check("abort_mux", mux_select, model_sel(applied));
         return;
      end
      frame_sync = 1'b1;
      step();
      frame_sync = 1'b0;
      // cycle S+c: mute for c in 1..F+1, new delay visible from c=2, done at c=F+2
      for (int c = 1; c <= F + 1; c++) begin
         if (c == rst_at) begin
            rst = 1'b1;
            step();
            clear_inputs();
            check("rst_mute", 32'(data_mute), 32'd0);
            check("rst_delay", 32'(delay_value), 32'd0);
            check("rst_mux", mux_select, 32'h76543210);
            check("rst_done", 32'(cfg_bus.cfg_done), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            rst = 1'b0;
            #1;
            check("rst_ready", 32'(cfg_bus.cfg_ready), 32'd1);
            applied = 0;
            return;
         end
         check("flush_mute", 32'(data_mute), 32'd1);
         check("flush_busy", 32'(busy), 32'd1);
         check("flush_done", 32'(cfg_bus.cfg_done), 32'd0);
         check("flush_delay", 32'(delay_value), 32'((c >= 2) ? d : applied));
         check("flush_mux", mux_select, model_sel((c >= 2) ? d : applied));
         frame_sync        = 1'($urandom_range(0, 1));
         cfg_bus.cfg_abort = 1'($urandom_range(0, 1));
         cfg_bus.cfg_valid = 1'($urandom_range(0, 1));
         cfg_bus.cfg_delay = DLY_W'($urandom_range(0, 7));
         if (c == F + 1) exp_q.push_back(32'(d));
         step();
      end
      clear_inputs();
      check("end_mute", 32'(data_mute), 32'd0);
      check("end_done", 32'(cfg_bus.cfg_done), 32'd1);
      check("end_busy", 32'(busy), 32'd0);
      check("end_ready", 32'(cfg_bus.cfg_ready), 32'd1);
      check("end_delay", 32'(delay_value), 32'(d));
      applied = d;
   endtask

   initial begin
      rst               = 1'b1;
      cfg_bus.cfg_delay = '0;
      clear_inputs();
      repeat (3) step();
      check("ready_in_rst", 32'(cfg_bus.cfg_ready), 32'd0);
      rst = 1'b0;
      #1;
      check("rst_delay0", 32'(delay_value), 32'd0);
      check("rst_mux0", mux_select, 32'h76543210);
      check("rst_mute0", 32'(data_mute), 32'd0);
      check("rst_ready0", 32'(cfg_bus.cfg_ready), 32'd1);
      check("rst_busy0", 32'(busy), 32'd0);
      check("rst_state0", 32'(dbg_state), 32'(ST_IDLE));

      request(7, 1'b0, 2, 1'b1, 0);                 // abort wins over frame_sync
      check("abort_keeps0", 32'(delay_value), 32'd0);
      request(3, 1'b0, 4, 1'b0, 0);                 // frame_sync 5 cycles after accept
      check("mux_d3", mux_select, 32'hA9876543);
      request(3, 1'b0, 0, 1'b0, 0);                 // no-op
      check("noop_keeps_mux", mux_select, 32'hA9876543);
      request(7, 1'b1, 0, 1'b0, 0);                 // accept-cycle frame_sync ignored
      check("mux_d7", mux_select, 32'hEDCBA987);
      request(5, 1'b0, 1, 1'b0, 2);                 // reset on 2nd mute cycle

      for (int n = 0; n < 40; n++) begin
         request($urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 6),
                 ($urandom_range(0, 3) == 0), 0);
      end
      repeat (3) step();
      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
